trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
//   Trap sequencer for the M-mode CSR file. Arbitrates synchronous exceptions against
//   enabled interrupts and drains the pipeline. Drives the CSR file's trap-entry strobe,
//   cause and mepc, then redirects fetch to the trap vector.
//   Also sequences mret by redirecting fetch to mepc.
//   Sits between the execute stage, the CSR file and the fetch PC mux.
// PARAMETERS
//   XLEN          32  datapath / CSR width
//   DRAIN_CYCLES  2   cycles flush_o is held before trap commit (>=1)
// PORTS
//   clk_i             in   1     clock
//   rst_ni            in   1     reset; asynchronous, active-low
//   exc_valid_i       in   1     synchronous exception from execute
//   exc_cause_i       in   4     exception code (bit31 of mcause = 0)
//   exc_pc_i          in   XLEN  PC of faulting instruction
//   irq_i             in   3     level irq lines {meip, mtip, msip}
//   mstatus_mie_i     in   1     mstatus.MIE from CSR file
//   mie_i             in   XLEN  mie CSR (bits 11/7/3 used)
//   cur_pc_i          in   XLEN  PC of oldest uncommitted instr (interrupt mepc)
//   mret_i            in   1     mret retiring in execute
//   mtvec_i           in   XLEN  mtvec CSR
//   mepc_i            in   XLEN  mepc CSR
//   trap_active_o     out  1     1-cycle trap-entry strobe to CSR file
//   trap_cause_o      out  XLEN  mcause value, valid with trap_active_o
//   trap_mepc_o       out  XLEN  mepc value, valid with trap_active_o
//   flush_o           out  1     kill younger pipeline instructions
//   stall_o           out  1     hold fetch/decode
//   redirect_valid_o  out  1     1-cycle fetch redirect strobe
//   redirect_pc_o     out  XLEN  redirect target, valid with redirect_valid_o
//   busy_o            out  1     FSM not IDLE
// BEHAVIOUR
//   Reset: async to IDLE. All outputs 0. Latched cause/pc/counter cleared. Mid-operation
//     reset aborts the sequence at once; no trap_active_o or redirect follows.
//   Interrupt pending: irq_pend = mstatus_mie_i & ({irq_i} & {mie_i[11],mie_i[7],mie_i[3]}).
//   Priority (IDLE only): exc_valid_i > mret_i > MEI(11) > MSI(3) > MTI(7).
//   States: IDLE, DRAIN, COMMIT, REDIRECT, MRET.
//   IDLE:
//     - exception: latch cause={28'b0,exc_cause_i}, pc=exc_pc_i; go to DRAIN.
//     - else mret_i: latch target=mepc_i; go to MRET.
//     - else irq_pend!=0: latch cause={1'b1,27'b0,code}, pc=cur_pc_i; go to DRAIN.
//   DRAIN:
//     - flush_o=1 and stall_o=1 for DRAIN_CYCLES cycles (down-counter), then COMMIT.
//     - New exc/irq/mret inputs are ignored.
//   COMMIT: trap_active_o=1 for exactly 1 cycle; stall_o=1. Next state REDIRECT.
//   REDIRECT:
//     - redirect_valid_o=1 for 1 cycle; stall_o=1. Next state IDLE.
//     - Target base = {mtvec_i[XLEN-1:2],2'b00}.
//     - If mtvec_i[1:0]==2'b01 and interrupt: base + 4*code; else base.
//     - Sum wraps mod 2^XLEN.
//     - mtvec_i is sampled in REDIRECT, so a write in COMMIT is honoured.
//   MRET:
//     - flush_o=1 and redirect_valid_o=1 with redirect_pc_o=latched mepc, 1 cycle.
//     - Next state IDLE. No trap_active_o.
//   Outputs: Moore, decoded from registered state. trap_cause_o/trap_mepc_o/redirect_pc_o
//     come from latched registers and are 0 outside their strobe cycle.
//   Latency: request seen at cycle N in IDLE -> flush N+1..N+DRAIN_CYCLES ->
//     trap_active N+DRAIN_CYCLES+1 -> redirect N+DRAIN_CYCLES+2. mret: redirect at N+1.
//   busy_o=1 in every non-IDLE state. An irq that deasserts after being latched still
//     completes its trap.
//   An irq still pending on return to IDLE is re-evaluated in that same IDLE cycle.
// TESTING (DRAIN_CYCLES=2, mtvec_i=0x8000_0100 unless noted)
//   1. exc_valid_i, cause 2, exc_pc 0x0000_0100 at cycle 0 -> flush_o cycles 1-2;
//      trap_active_o cycle 3 with cause 0x0000_0002, mepc 0x100;
//      redirect_valid_o cycle 4 with pc 0x8000_0100.
//   2. mtvec_i=0x8000_0101, MIE=1, mie_i[7]=1, mtip at cycle 0, cur_pc 0x240 ->
//      cause 0x8000_0007, mepc 0x240, redirect pc 0x8000_011C.
//   3. exc (cause 11) + meip, both enabled, same cycle -> cause 0x0000_000B.
//      meip still high on return to IDLE -> second trap, cause 0x8000_000B.
//   4. mret_i with mepc_i=0x0000_0200 -> redirect_valid_o + flush_o next cycle,
//      pc 0x200, trap_active_o never set.
//   5. mtip with mstatus_mie_i=0 -> no outputs. exc_valid_i pulsed during DRAIN ->
//      ignored, only one trap_active_o.
//   6. rst_ni low during DRAIN cycle 1 -> all outputs 0 at once, busy_o=0;
//      after release, no trap_active_o or redirect occurs.

Source files
------------

// File: rtl/trap_ctrl_if.sv
// Bundle of execute / CSR-file / fetch signals around the trap sequencer.
// slave is the sequencer's view; master is the surrounding pipeline's view.
interface trap_ctrl_if #(
   parameter int XLEN = 32
);
   logic            exc_valid_i;
   logic [3:0]      exc_cause_i;
   logic [XLEN-1:0] exc_pc_i;
   logic [2:0]      irq_i;
   logic            mstatus_mie_i;
   logic [XLEN-1:0] mie_i;
   logic [XLEN-1:0] cur_pc_i;
   logic            mret_i;
   logic [XLEN-1:0] mtvec_i;
   logic [XLEN-1:0] mepc_i;
   logic            trap_active_o;
   logic [XLEN-1:0] trap_cause_o;
   logic [XLEN-1:0] trap_mepc_o;
   logic            flush_o;
   logic            stall_o;
   logic            redirect_valid_o;
   logic [XLEN-1:0] redirect_pc_o;
   logic            busy_o;

   modport slave (
      input  exc_valid_i, exc_cause_i, exc_pc_i, irq_i, mstatus_mie_i, mie_i,
             cur_pc_i, mret_i, mtvec_i, mepc_i,
      output trap_active_o, trap_cause_o, trap_mepc_o, flush_o, stall_o,
             redirect_valid_o, redirect_pc_o, busy_o
   );

   modport master (
      output exc_valid_i, exc_cause_i, exc_pc_i, irq_i, mstatus_mie_i, mie_i,
             cur_pc_i, mret_i, mtvec_i, mepc_i,
      input  trap_active_o, trap_cause_o, trap_mepc_o, flush_o, stall_o,
             redirect_valid_o, redirect_pc_o, busy_o
   );
endinterface

// File: rtl/trap_ctrl.sv
// M-mode trap sequencer: arbitrates exceptions, interrupts and mret, drains the
// pipeline, strobes trap entry into the CSR file and redirects fetch.
module trap_ctrl #(
   parameter int XLEN         = 32,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   trap_ctrl_if.slave  bus
);
   localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAIN,
      S_COMMIT,
      S_REDIRECT,
      S_MRET
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [XLEN-1:0] r_cause;
   logic [XLEN-1:0] r_pc;
   logic            r_flush;
   logic            r_stall;
   logic            r_trap_active;
   logic            r_redirect_valid;

   logic [2:0]      w_irq_pend;
   logic [3:0]      w_irq_code;
   logic [XLEN-1:0] w_vec_base;
   logic [XLEN-1:0] w_vec_pc;

   // irq_i is {meip, mtip, msip}; enables sit at mie bits 11/7/3
   assign w_irq_pend = {3{bus.mstatus_mie_i}} & bus.irq_i
                     & {bus.mie_i[11], bus.mie_i[7], bus.mie_i[3]};

   always_comb begin
      w_irq_code = 4'd0;
      if (w_irq_pend[2])      w_irq_code = 4'd11;
      else if (w_irq_pend[0]) w_irq_code = 4'd3;
      else if (w_irq_pend[1]) w_irq_code = 4'd7;
   end

   // mtvec is read live in REDIRECT so a CSR write during COMMIT takes effect
   assign w_vec_base = {bus.mtvec_i[XLEN-1:2], 2'b00};
   assign w_vec_pc   = (bus.mtvec_i[1:0] == 2'b01 && r_cause[XLEN-1])
                     ? w_vec_base + {{(XLEN-6){1'b0}}, r_cause[3:0], 2'b00}
                     : w_vec_base;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state          <= S_IDLE;
         r_cnt            <= '0;
         r_cause          <= '0;
         r_pc             <= '0;
         r_flush          <= 1'b0;
         r_stall          <= 1'b0;
         r_trap_active    <= 1'b0;
         r_redirect_valid <= 1'b0;
      end else begin
         r_flush          <= 1'b0;
         r_stall          <= 1'b0;
         r_trap_active    <= 1'b0;
         r_redirect_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.exc_valid_i) begin
                  r_cause <= {{(XLEN-4){1'b0}}, bus.exc_cause_i};
                  r_pc    <= bus.exc_pc_i;
                  r_cnt   <= CW'(DRAIN_CYCLES - 1);
                  r_flush <= 1'b1;
                  r_stall <= 1'b1;
                  r_state <= S_DRAIN;
               end else if (bus.mret_i) begin
                  r_pc             <= bus.mepc_i;
                  r_flush          <= 1'b1;
                  r_redirect_valid <= 1'b1;
                  r_state          <= S_MRET;
               end else if (w_irq_pend != 3'b000) begin
                  r_cause <= {1'b1, {(XLEN-5){1'b0}}, w_irq_code};
                  r_pc    <= bus.cur_pc_i;
                  r_cnt   <= CW'(DRAIN_CYCLES - 1);
                  r_flush <= 1'b1;
                  r_stall <= 1'b1;
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               r_stall <= 1'b1;
               if (r_cnt == '0) begin
                  r_trap_active <= 1'b1;
                  r_state       <= S_COMMIT;
               end else begin
                  r_cnt   <= r_cnt - CW'(1);
                  r_flush <= 1'b1;
               end
            end
            S_COMMIT: begin
               r_stall          <= 1'b1;
               r_redirect_valid <= 1'b1;
               r_state          <= S_REDIRECT;
            end
            S_REDIRECT: r_state <= S_IDLE;
            S_MRET:     r_state <= S_IDLE;
            default:    r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.flush_o          = r_flush;
   assign bus.stall_o          = r_stall;
   assign bus.trap_active_o    = r_trap_active;
   assign bus.trap_cause_o     = r_trap_active ? r_cause : '0;
   assign bus.trap_mepc_o      = r_trap_active ? r_pc : '0;
   assign bus.redirect_valid_o = r_redirect_valid;
   assign bus.redirect_pc_o    = !r_redirect_valid   ? '0
                               : (r_state == S_MRET) ? r_pc
                               : w_vec_pc;
   assign bus.busy_o           = (r_state != S_IDLE);

   logic w_unused_mie;
   assign w_unused_mie = &{1'b0, bus.mie_i};
endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboarded bench for trap_ctrl: each stimulus pushes the strobes it should
// cause, and a negedge monitor pops and compares them as the DUT emits them.
module tb_trap_ctrl;
   localparam int K_FLUSH = 0;
   localparam int K_STALL = 1;
   localparam int K_TRAP  = 2;
   localparam int K_REDIR = 3;

   typedef struct {
      int          kind;
      int          cyc;
      logic [31:0] a;
      logic [31:0] b;
   } ev_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cyc   = 0;
   int   vectors     = 0;
   int   miscompares = 0;
   ev_t  exp_q[$];

   ev_t         m_e;
   logic        m_hit;
   logic [31:0] m_a;
   logic [31:0] m_b;

   trap_ctrl_if #(.XLEN(32)) bus ();

   trap_ctrl #(.XLEN(32), .DRAIN_CYCLES(2)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         m_a = 32'h0;
         m_b = 32'h0;
         case (k)
            K_FLUSH: m_hit = (bus.flush_o === 1'b1);
            K_STALL: m_hit = (bus.stall_o === 1'b1);
            K_TRAP: begin
               m_hit = (bus.trap_active_o === 1'b1);
               m_a   = bus.trap_cause_o;
               m_b   = bus.trap_mepc_o;
            end
            default: begin
               m_hit = (bus.redirect_valid_o === 1'b1);
               m_a   = bus.redirect_pc_o;
            end
         endcase
         if (m_hit) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_event kind=%0d cycle=%0d got a=%h b=%h, required none",
                        k, cyc, m_a, m_b);
            end else begin
               m_e = exp_q.pop_front();
               if (m_e.kind != k || m_e.cyc != cyc || m_e.a !== m_a || m_e.b !== m_b) begin
                  miscompares++;
                  $display("FAIL event got kind=%0d cyc=%0d a=%h b=%h, required kind=%0d cyc=%0d a=%h b=%h",
                           k, cyc, m_a, m_b, m_e.kind, m_e.cyc, m_e.a, m_e.b);
               end else begin
                  $display("event kind=%0d cyc=%0d a=%h b=%h ok", k, cyc, m_a, m_b);
               end
            end
         end
      end
      vectors++;
      if ((bus.trap_active_o !== 1'b1 && (bus.trap_cause_o !== 32'h0 || bus.trap_mepc_o !== 32'h0)) ||
          (bus.redirect_valid_o !== 1'b1 && bus.redirect_pc_o !== 32'h0)) begin
         miscompares++;
         $display("FAIL idle_payload cycle=%0d got cause=%h mepc=%h rpc=%h, required 0",
                  cyc, bus.trap_cause_o, bus.trap_mepc_o, bus.redirect_pc_o);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_ev(input int kind, input int c, input logic [31:0] a, input logic [31:0] b);
      ev_t e;
      e.kind = kind; e.cyc = c; e.a = a; e.b = b;
      exp_q.push_back(e);
   endtask

   task automatic expect_trap(input int c0, input logic [31:0] cause, input logic [31:0] mepc,
                              input logic [31:0] pc);
      expect_ev(K_FLUSH, c0 + 1, 0, 0);
      expect_ev(K_STALL, c0 + 1, 0, 0);
      expect_ev(K_FLUSH, c0 + 2, 0, 0);
      expect_ev(K_STALL, c0 + 2, 0, 0);
      expect_ev(K_STALL, c0 + 3, 0, 0);
      expect_ev(K_TRAP,  c0 + 3, cause, mepc);
      expect_ev(K_STALL, c0 + 4, 0, 0);
      expect_ev(K_REDIR, c0 + 4, pc, 0);
   endtask

   task automatic idle_inputs();
      bus.exc_valid_i   = 1'b0;
      bus.exc_cause_i   = 4'h0;
      bus.exc_pc_i      = 32'h0;
      bus.irq_i         = 3'b000;
      bus.mstatus_mie_i = 1'b0;
      bus.mie_i         = 32'h0;
      bus.cur_pc_i      = 32'h0;
      bus.mret_i        = 1'b0;
      bus.mtvec_i       = 32'h8000_0100;
      bus.mepc_i        = 32'h0;
   endtask

   task automatic test_drained(input string name);
      vectors++;
      if (exp_q.size() != 0 || bus.busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_drained got pending=%0d busy=%b, required pending=0 busy=0",
                  name, exp_q.size(), bus.busy_o);
         exp_q.delete();
      end else begin
         $display("%s complete, scoreboard empty", name);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      #1 rst_n = 1'b0;
      #2;
      vectors++;
      if ({bus.flush_o, bus.stall_o, bus.trap_active_o, bus.redirect_valid_o, bus.busy_o} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_flags got %b, required 00000",
                  {bus.flush_o, bus.stall_o, bus.trap_active_o, bus.redirect_valid_o, bus.busy_o});
      end
      vectors++;
      if ({bus.trap_cause_o, bus.trap_mepc_o, bus.redirect_pc_o} !== 96'h0) begin
         miscompares++;
         $display("FAIL reset_payload got %h %h %h, required 0",
                  bus.trap_cause_o, bus.trap_mepc_o, bus.redirect_pc_o);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      test_drained("reset");
   endtask

   task automatic test_exception();
      int c0 = cyc;
      expect_trap(c0, 32'h0000_0002, 32'h0000_0100, 32'h8000_0100);
      bus.exc_valid_i = 1'b1; bus.exc_cause_i = 4'd2; bus.exc_pc_i = 32'h0000_0100;
      tick();
      bus.exc_valid_i = 1'b0;
      vectors++;
      if (bus.busy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL exc_busy got %b, required 1", bus.busy_o);
      end
      repeat (6) tick();
      test_drained("exception");
   endtask

   task automatic test_irq_vectored();
      int c0 = cyc;
      expect_trap(c0, 32'h8000_0007, 32'h0000_0240, 32'h8000_011C);
      bus.mtvec_i = 32'h8000_0101; bus.mstatus_mie_i = 1'b1; bus.mie_i = 32'h80;
      bus.irq_i = 3'b010; bus.cur_pc_i = 32'h0000_0240;
      tick();
      bus.irq_i = 3'b000; bus.cur_pc_i = 32'h0000_0999;
      repeat (7) tick();
      idle_inputs();
      test_drained("irq_vectored");
   endtask

   task automatic test_back_to_back();
      int c0 = cyc;
      expect_trap(c0,     32'h0000_000B, 32'h0000_0300, 32'h8000_0100);
      expect_trap(c0 + 5, 32'h8000_000B, 32'h0000_0400, 32'h8000_0100);
      bus.exc_valid_i = 1'b1; bus.exc_cause_i = 4'd11; bus.exc_pc_i = 32'h0000_0300;
      bus.irq_i = 3'b100; bus.mie_i = 32'h800; bus.mstatus_mie_i = 1'b1;
      bus.cur_pc_i = 32'h0000_0400;
      tick();
      bus.exc_valid_i = 1'b0;
      repeat (5) tick();
      bus.irq_i = 3'b000;
      repeat (8) tick();
      idle_inputs();
      test_drained("back_to_back");
   endtask

   task automatic test_mret();
      int c0 = cyc;
      expect_ev(K_FLUSH, c0 + 1, 0, 0);
      expect_ev(K_REDIR, c0 + 1, 32'h0000_0200, 0);
      bus.mret_i = 1'b1; bus.mepc_i = 32'h0000_0200;
      tick();
      bus.mret_i = 1'b0; bus.mepc_i = 32'h0000_0DEAD;
      vectors++;
      if (bus.busy_o !== 1'b1 || bus.trap_active_o !== 1'b0) begin
         miscompares++;
         $display("FAIL mret_state got busy=%b trap=%b, required busy=1 trap=0",
                  bus.busy_o, bus.trap_active_o);
      end
      repeat (4) tick();
      test_drained("mret");
   endtask

   task automatic test_masked_and_ignore();
      int c0;
      bus.mstatus_mie_i = 1'b0; bus.mie_i = 32'h80; bus.irq_i = 3'b010;
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if (bus.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL masked_busy cycle=%0d got %b, required 0", cyc, bus.busy_o);
         end
      end
      c0 = cyc;
      expect_trap(c0, 32'h0000_0004, 32'h0000_0500, 32'h8000_0100);
      bus.exc_valid_i = 1'b1; bus.exc_cause_i = 4'd4; bus.exc_pc_i = 32'h0000_0500;
      tick();
      bus.exc_cause_i = 4'd6; bus.exc_pc_i = 32'h0000_0600;
      tick();
      bus.exc_valid_i = 1'b0; bus.mret_i = 1'b1; bus.mepc_i = 32'h0000_0700;
      tick();
      bus.mret_i = 1'b0;
      repeat (6) tick();
      idle_inputs();
      test_drained("masked_and_ignore");
   endtask

   task automatic test_reset_mid_drain();
      bus.exc_valid_i = 1'b1; bus.exc_cause_i = 4'd5; bus.exc_pc_i = 32'h0000_0800;
      tick();
      bus.exc_valid_i = 1'b0;
      vectors++;
      if (bus.flush_o !== 1'b1 || bus.busy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL drain_entry got flush=%b busy=%b, required 1 1", bus.flush_o, bus.busy_o);
      end
      #1 rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus.flush_o, bus.stall_o, bus.trap_active_o, bus.redirect_valid_o, bus.busy_o} !== 5'b0) begin
         miscompares++;
         $display("FAIL midreset_flags got %b, required 00000",
                  {bus.flush_o, bus.stall_o, bus.trap_active_o, bus.redirect_valid_o, bus.busy_o});
      end
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         vectors++;
         if (bus.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_busy cycle=%0d got %b, required 0", cyc, bus.busy_o);
         end
      end
      test_drained("reset_mid_drain");
   endtask

   initial begin
      test_reset();
      test_exception();
      test_irq_vectored();
      test_back_to_back();
      test_mret();
      test_masked_and_ignore();
      test_reset_mid_drain();
      repeat (2) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
